uart_rx_fifo: RTL and testbench

Receive-side buffer directly downstream of the UART receiver (`rx`). It pulls each completed byte out of the receiver by pulsing the receiver's `readdata`, and clears receiver errors on that same pulse when needed. Each byte is stored with its framing/overrun status in a show-ahead FIFO that the host drains at its own pace. When the FIFO is full it stops acknowledging, so backpressure appears upstream as the receiver's own overrun flag.

---
 rtl/uart_rx_fifo.sv | 141 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side buffer behind the UART receiver.
// Pulls each completed byte out of the receiver with a one-cycle readdata
// pulse, clears receiver errors on that same pulse, and queues
// {overrun, framing, data} in a show-ahead FIFO for the host. When the FIFO
// is full it stops acknowledging, so the receiver's overrun flag reports the
// backpressure.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_ready,
  input  logic          rx_framing,
  input  logic          rx_overrun,
  output logic          rx_read,
  output logic          rx_clearerr,
  input  logic          rd,
  output logic [7:0]    dout,
  output logic          dout_framing,
  output logic          dout_overrun,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          underflow,
  input  logic          clr_underflow
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [9:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0] r_count;
  logic        r_empty;
  logic        r_full;
  logic [0:0]  r_state;
  logic        r_rx_read;
  logic        r_rx_clearerr;
  logic        r_underflow;

  logic        w_push;
  logic        w_pop;
  logic [AW:0] w_count_nxt;
  logic [9:0]  w_head;

  // A byte is taken only from IDLE, with a byte offered and room left; both
  // gates use the registered full flag so a same-cycle pop cannot open a slot.
  assign w_push = (r_state == S_IDLE) && rx_ready && !r_full;
  assign w_pop  = rd && !r_empty;
  assign w_head = r_mem[r_rptr];

  // Next occupancy from push/pop; a simultaneous push and pop cancel out.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + (AW+1)'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - (AW+1)'(1);
    end
  end

  // Entry storage, written on each captured byte.
  // NOTE: the storage array has no reset; empty gates what the host sees, so
  // stale contents are never observable and the array can map to plain RAM.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= {rx_overrun, rx_framing, rx_data};
    end
  end

  // Pointers, occupancy and the registered empty/full flags.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here sees the pre-edge values of all the others.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
    end
  end

  // Pull handshake: pulse readdata (and clearerr on error) on capture, then
  // wait for the receiver to drop dataready before taking another byte.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_rx_read     <= 1'b0;
      r_rx_clearerr <= 1'b0;
    end else begin
      r_rx_read     <= 1'b0;
      r_rx_clearerr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_push) begin
            r_rx_read     <= 1'b1;
            r_rx_clearerr <= rx_framing | rx_overrun;
            r_state       <= S_WAIT;
          end
        end
        default: begin
          if (!rx_ready) r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky underflow: set on a pop of an empty FIFO, set beats clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_underflow <= 1'b0;
    end else if (rd && r_empty) begin
      r_underflow <= 1'b1;
    end else if (clr_underflow) begin
      r_underflow <= 1'b0;
    end
  end

  assign rx_read      = r_rx_read;
  assign rx_clearerr  = r_rx_clearerr;
  assign dout         = r_empty ? 8'h00 : w_head[7:0];
  assign dout_framing = r_empty ? 1'b0  : w_head[8];
  assign dout_overrun = r_empty ? 1'b0  : w_head[9];
  assign empty        = r_empty;
  assign full         = r_full;
  assign count        = r_count;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed vector table, hand-written corner
// sequences (full/backpressure, wrap with simultaneous push/pop, reset in
// the middle of a handshake) and a randomized receiver/host run against a
// queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_ready = 1'b0;
  logic          rx_framing = 1'b0;
  logic          rx_overrun = 1'b0;
  logic          rx_read;
  logic          rx_clearerr;
  logic          rd = 1'b0;
  logic [7:0]    dout;
  logic          dout_framing;
  logic          dout_overrun;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          underflow;
  logic          clr_underflow = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_framing   (rx_framing),
    .rx_overrun   (rx_overrun),
    .rx_read      (rx_read),
    .rx_clearerr  (rx_clearerr),
    .rd           (rd),
    .dout         (dout),
    .dout_framing (dout_framing),
    .dout_overrun (dout_overrun),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .underflow    (underflow),
    .clr_underflow(clr_underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rdy;
    logic [7:0] d;
    logic       fr;
    logic       ov;
    logic       rd;
    logic       clr;
    logic       e_read;
    logic       e_clrerr;
    logic [4:0] e_count;
    logic       e_empty;
    logic       e_full;
    logic [7:0] e_dout;
    logic       e_dfr;
    logic       e_dov;
    logic       e_uf;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic rdy, input logic [7:0] d,
                              input logic fr, input logic ov,
                              input logic rdi, input logic clr,
                              input logic er, input logic ec,
                              input logic [4:0] cnt, input logic em,
                              input logic fu, input logic [7:0] de,
                              input logic dfr, input logic dov,
                              input logic uf);
    vec_t v;
    v.rdy = rdy; v.d = d; v.fr = fr; v.ov = ov; v.rd = rdi; v.clr = clr;
    v.e_read = er; v.e_clrerr = ec; v.e_count = cnt; v.e_empty = em;
    v.e_full = fu; v.e_dout = de; v.e_dfr = dfr; v.e_dov = dov; v.e_uf = uf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, cross the rising edge, and settle 1 time unit.
  task automatic cyc(input logic rdy, input logic [7:0] d, input logic fr,
                     input logic ov, input logic rdi, input logic clr);
    rx_ready = rdy; rx_data = d; rx_framing = fr; rx_overrun = ov;
    rd = rdi; clr_underflow = clr;
    @(posedge clock);
    #1;
  endtask

  // Full receiver handshake for one clean byte, dataready held one cycle
  // past the readdata pulse.
  task automatic push_byte(input logic [7:0] d, input string tag);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, "_read"}, rx_read, 1);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, "_read_off"}, rx_read, 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rx_ready = 1'b0; rd = 1'b0; clr_underflow = 1'b0;
    #2 reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin : main
    logic [7:0] eq[$];
    logic [9:0] q[$];
    logic       open_m, uf_m, take, pop, full_m, empty_m;
    logic       rv_busy, pend_drop, last_read, rd_b, clr_b;
    logic [7:0] rv_d;
    logic       rv_fr, rv_ov;
    int         rd_pct;

    // Reset state
    @(posedge clock);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_read", rx_read, 0);
    check("rst_clrerr", rx_clearerr, 0);
    check("rst_uf", underflow, 0);
    check("rst_dout", dout, 0);
    reset = 1'b1;

    // Directed table
    tbl[0]  = mk(1, 8'h55, 0, 0, 0, 0, 1, 0, 1, 0, 0, 8'h55, 0, 0, 0);
    tbl[1]  = mk(1, 8'h55, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h55, 0, 0, 0);
    tbl[2]  = mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h55, 0, 0, 0);
    tbl[3]  = mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0);
    tbl[4]  = mk(1, 8'h0E, 1, 0, 0, 0, 1, 1, 1, 0, 0, 8'h0E, 1, 0, 0);
    tbl[5]  = mk(1, 8'h0E, 1, 0, 0, 0, 0, 0, 1, 0, 0, 8'h0E, 1, 0, 0);
    tbl[6]  = mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h0E, 1, 0, 0);
    tbl[7]  = mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0);
    tbl[8]  = mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 1);
    tbl[9]  = mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 1);
    tbl[10] = mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0);
    tbl[11] = mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 1, 0, 8'h00, 0, 0, 1);
    tbl[12] = mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0);
    tbl[13] = mk(1, 8'hA5, 0, 1, 0, 0, 1, 1, 1, 0, 0, 8'hA5, 0, 1, 0);
    tbl[14] = mk(1, 8'hA5, 0, 1, 0, 0, 0, 0, 1, 0, 0, 8'hA5, 0, 1, 0);
    tbl[15] = mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'hA5, 0, 1, 0);
    tbl[16] = mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0);
    tbl[17] = mk(1, 8'h3C, 0, 0, 1, 0, 1, 0, 1, 0, 0, 8'h3C, 0, 0, 1);
    tbl[18] = mk(1, 8'h3C, 0, 0, 0, 1, 0, 0, 1, 0, 0, 8'h3C, 0, 0, 0);
    tbl[19] = mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].rdy, tbl[i].d, tbl[i].fr, tbl[i].ov, tbl[i].rd, tbl[i].clr);
      check($sformatf("v%0d_read", i), rx_read, tbl[i].e_read);
      check($sformatf("v%0d_clrerr", i), rx_clearerr, tbl[i].e_clrerr);
      check($sformatf("v%0d_count", i), count, tbl[i].e_count);
      check($sformatf("v%0d_empty", i), empty, tbl[i].e_empty);
      check($sformatf("v%0d_full", i), full, tbl[i].e_full);
      check($sformatf("v%0d_dout", i), dout, tbl[i].e_dout);
      check($sformatf("v%0d_dfr", i), dout_framing, tbl[i].e_dfr);
      check($sformatf("v%0d_dov", i), dout_overrun, tbl[i].e_dov);
      check($sformatf("v%0d_uf", i), underflow, tbl[i].e_uf);
    end

    // Fill to DEPTH, then backpressure on a 17th byte
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i), "fill");
    check("fill_count", count, DEPTH);
    check("fill_full", full, 1);
    check("fill_head", dout, 8'h00);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
      check("bp_read", rx_read, 0);
      check("bp_count", count, DEPTH);
    end
    cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_pop_read", rx_read, 0);
    check("bp_pop_count", count, DEPTH - 1);
    check("bp_pop_full", full, 0);
    check("bp_pop_dout", dout, 8'h01);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_cap_read", rx_read, 1);
    check("bp_cap_count", count, DEPTH);
    check("bp_cap_full", full, 1);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < DEPTH; i++) begin
      check("drain_dout", dout, 8'(i));
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("drain_last", dout, 8'hAA);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("drain_empty", empty, 1);
    check("drain_count", count, 0);

    // Count 3 with simultaneous push/pop, walking wptr across the wrap
    eq.delete();
    for (int i = 0; i < 3; i++) begin
      push_byte(8'h20 + 8'(i), "wrap_pre");
      eq.push_back(8'h20 + 8'(i));
    end
    for (int k = 0; k < 14; k++) begin
      cyc(1'b1, 8'h30 + 8'(k), 1'b0, 1'b0, 1'b1, 1'b0);
      void'(eq.pop_front());
      eq.push_back(8'h30 + 8'(k));
      check("wrap_read", rx_read, 1);
      check("wrap_count", count, 3);
      check("wrap_dout", dout, eq[0]);
      cyc(1'b1, 8'h30 + 8'(k), 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    while (eq.size() > 0) begin
      check("wrap_drain", dout, eq.pop_front());
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("wrap_empty", empty, 1);

    // Reset in WAIT with count 5, receiver still offering afterwards
    for (int i = 0; i < 4; i++) push_byte(8'h40 + 8'(i), "rw_pre");
    cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rw_read", rx_read, 1);
    check("rw_count", count, 5);
    #2 reset = 1'b0;
    #1;
    check("rw_rst_count", count, 0);
    check("rw_rst_empty", empty, 1);
    check("rw_rst_read", rx_read, 0);
    check("rw_rst_dout", dout, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rw_recap_read", rx_read, 1);
    check("rw_recap_count", count, 1);
    check("rw_recap_dout", dout, 8'h77);

    // Randomized receiver and host against a queue model
    do_reset();
    q.delete();
    open_m = 0; uf_m = 0;
    rv_busy = 0; pend_drop = 0; last_read = 0;
    rv_d = '0; rv_fr = 0; rv_ov = 0;
    for (int i = 0; i < 800; i++) begin
      rd_pct = (i < 400) ? 20 : 70;
      if (rv_busy) begin
        if (pend_drop) begin
          rv_busy = 0; pend_drop = 0;
        end else if (last_read) begin
          pend_drop = 1;
        end
      end else if ($urandom_range(99) < 60) begin
        rv_busy = 1;
        rv_d  = 8'($urandom);
        rv_fr = ($urandom_range(7) == 0);
        rv_ov = ($urandom_range(7) == 0);
      end
      rd_b  = ($urandom_range(99) < rd_pct);
      clr_b = ($urandom_range(15) == 0);

      full_m  = (q.size() == DEPTH);
      empty_m = (q.size() == 0);
      take    = rv_busy && !open_m && !full_m;
      pop     = rd_b && !empty_m;
      if (pop)  void'(q.pop_front());
      if (take) q.push_back({rv_ov, rv_fr, rv_d});
      if (take) open_m = 1;
      else if (!rv_busy) open_m = 0;
      if (rd_b && empty_m) uf_m = 1;
      else if (clr_b) uf_m = 0;

      cyc(rv_busy, rv_d, rv_fr, rv_ov, rd_b, clr_b);
      last_read = rx_read;

      check("rnd_read", rx_read, take);
      check("rnd_clrerr", rx_clearerr, take && (rv_fr || rv_ov));
      check("rnd_count", count, q.size());
      check("rnd_empty", empty, q.size() == 0);
      check("rnd_full", full, q.size() == DEPTH);
      check("rnd_head", {dout_overrun, dout_framing, dout},
            (q.size() == 0) ? 10'h000 : q[0]);
      check("rnd_uf", underflow, uf_m);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
